// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// The master modport is the environment and the slave modport is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_active;
  logic                 tx_send;
  logic [7:0]           tx_data;
  logic                 busy;
  logic                 abort;

  modport master (
    output req_valid, req_data, req_last, tx_active,
    input  req_ready, grant, tx_send, tx_data, busy, abort
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_active,
    output req_ready, grant, tx_send, tx_data, busy, abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one UART transmitter.
// Paces bytes on tx_active and drops stalled packets on a gap timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int GAP_TIMEOUT   = 16,
  parameter int START_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int MAXT = (GAP_TIMEOUT > START_TIMEOUT) ?
                        GAP_TIMEOUT : START_TIMEOUT;
  localparam int CW = $clog2(MAXT + 1);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP_TIMEOUT - 1);
  localparam logic [CW-1:0] START_END = CW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [NUM_REQ-1:0] r_grant, w_grant_next;
  logic [IW-1:0]      r_rr_ptr, w_rr_next;
  logic [IW-1:0]      w_owner, w_pick, w_ptr_inc;
  logic [IW:0]        w_sum;
  logic               w_found;
  logic               r_tx_send;
  logic [7:0]         r_tx_data;
  logic               r_last;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_owner_valid;
  logic               w_accept;
  logic               w_cnt_en;
  logic               w_abort;

  always_comb begin
    w_owner = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (r_grant[i]) w_owner = IW'(i);
  end

  assign w_ptr_inc = (w_owner == IW'(NUM_REQ - 1)) ?
                     '0 : w_owner + IW'(1);

  // Descending scan so the nearest valid requester after rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ))
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      if (bus.req_valid[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[IW-1:0];
      end
    end
  end

  assign w_ready = (r_state == S_LOAD && !bus.tx_active) ?
                   r_grant : '0;
  assign w_accept      = |(bus.req_valid & w_ready);
  assign w_owner_valid = |(bus.req_valid & r_grant);

  always_comb begin
    w_next       = r_state;
    w_grant_next = r_grant;
    w_rr_next    = r_rr_ptr;
    w_abort      = 1'b0;
    w_cnt_en     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_next = NUM_REQ'(1) << w_pick;
          w_next       = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_next = S_WAIT_START;
        end else if (!w_owner_valid) begin
          if (r_cnt == GAP_END) begin
            w_abort      = 1'b1;
            w_grant_next = '0;
            w_rr_next    = w_ptr_inc;
            w_next       = S_IDLE;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
      end
      S_WAIT_START: begin
        if (bus.tx_active || r_cnt == START_END)
          w_next = S_WAIT_DONE;
        else
          w_cnt_en = 1'b1;
      end
      S_WAIT_DONE: begin
        if (!bus.tx_active) begin
          if (r_last) begin
            w_grant_next = '0;
            w_rr_next    = w_ptr_inc;
            w_next       = S_IDLE;
          end else begin
            w_next = S_LOAD;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_tx_send <= 1'b0;
      r_tx_data <= '0;
      r_last    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_next;
      r_grant   <= w_grant_next;
      r_rr_ptr  <= w_rr_next;
      r_tx_send <= w_accept;
      if (w_accept) begin
        r_tx_data <= bus.req_data[{w_owner, 3'b000} +: 8];
        r_last    <= |(bus.req_last & r_grant);
      end
      // One counter serves both timeouts; it restarts on every state change.
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_cnt_en && r_cnt != {CW{1'b1}})
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.grant     = r_grant;
  assign bus.tx_send   = r_tx_send;
  assign bus.tx_data   = r_tx_data;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.abort     = w_abort;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: randomized packets against a packet-level
// round-robin model, plus directed gap-abort, lost-start and reset cases.
module tb_uart_tx_arbiter;
  localparam int NR      = 2;
  localparam int GAP_T   = 16;
  localparam int START_T = 4;

  typedef struct packed {
    logic [1:0] req;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .GAP_TIMEOUT(GAP_T),
    .START_TIMEOUT(START_T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [7:0] q_d [NR][$];
  bit   q_l [NR][$];
  int   gap [NR];
  int   m_ptr = 0;
  int   cyc_n = 0;
  int   tx_len_fix = 0;
  bit   tx_lost = 0;
  bit   tx_rnd_lost = 0;
  bit   gap_en = 0;
  int   send_t[$];
  int   act_from = 0;
  int   act_to = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy for a while after each start pulse.
  always @(negedge clk) begin
    int d, l;
    bit lost;
    if (!rst_n) begin
      act_from = 0;
      act_to = 0;
      bus.tx_active = 1'b0;
    end else begin
      if (bus.tx_send) begin
        d = (tx_len_fix != 0) ? 0 : $urandom_range(0, 2);
        l = (tx_len_fix != 0) ? tx_len_fix : $urandom_range(1, 6);
        lost = tx_lost || (tx_rnd_lost && ($urandom_range(0, 7) == 0));
        act_from = cyc_n + d;
        act_to = lost ? act_from : act_from + l;
      end
      bus.tx_active = (cyc_n >= act_from) && (cyc_n < act_to);
      cyc_n++;
    end
  end

  // Scoreboard: every start pulse must match the next expected byte.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n) begin
      if (bus.tx_send) begin
        send_t.push_back(cyc_n);
        if (exp_q.size() == 0) begin
          chk("unexpected_send", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("owner", 32'(bus.grant), 32'(NR'(1) << e.req));
          chk("tx_data", 32'(bus.tx_data), 32'(e.data));
        end
      end
      chk("ready_nonowner", 32'(bus.req_ready & ~bus.grant), 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog got running exp finished");
    $fatal(1, "watchdog expired");
  end

  // Reference: whole packets, round-robin from the pointer after the
  // previous owner, over everything currently queued.
  task automatic build_exp();
    int pos [NR];
    int left, pick, idx;
    bit lst;
    left = 0;
    for (int i = 0; i < NR; i++) begin
      pos[i] = 0;
      left += q_d[i].size();
    end
    while (left > 0) begin
      pick = -1;
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (pick < 0 && pos[idx] < q_d[idx].size()) pick = idx;
      end
      do begin
        exp_q.push_back(exp_t'{req: 2'(pick), data: q_d[pick][pos[pick]]});
        lst = q_l[pick][pos[pick]];
        pos[pick]++;
        left--;
      end while (!lst && pos[pick] < q_d[pick].size());
      m_ptr = (pick + 1) % NR;
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      if (q_d[i].size() > 0 && gap[i] == 0) begin
        bus.req_valid[i] = 1'b1;
        bus.req_data[8*i +: 8] = q_d[i][0];
        bus.req_last[i] = q_l[i][0];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_data[8*i +: 8] = 8'($urandom);
        bus.req_last[i] = 1'($urandom);
      end
    end
  endtask

  task automatic run_phase(input int budget);
    int n;
    logic [NR-1:0] acc;
    bit lst;
    n = 0;
    acc = '0;
    build_exp();
    while ((exp_q.size() > 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          lst = q_l[i].pop_front();
          void'(q_d[i].pop_front());
          if (!lst && gap_en) gap[i] = $urandom_range(0, 3);
        end else if (gap[i] > 0) begin
          gap[i]--;
        end
      end
      drive_reqs();
      #1;
      acc = bus.req_valid & bus.req_ready;
      n++;
    end
    chk("phase_done", exp_q.size(), 0);
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      q_d[i].delete();
      q_l[i].delete();
      gap[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic push_pkt(input int r, input logic [7:0] b0,
                          input logic [7:0] b1, input int len);
    q_d[r].push_back(b0);
    q_l[r].push_back(len == 1);
    if (len == 2) begin
      q_d[r].push_back(b1);
      q_l[r].push_back(1'b1);
    end
  endtask

  task automatic wait_accept(input int r, input string tag);
    int n;
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < 30) begin
      @(negedge clk);
      #1;
      n++;
      hit = bus.req_valid[r] & bus.req_ready[r];
    end
    chk(tag, 32'(hit), 1);
  endtask

  initial begin
    int n, cnt, np, len;
    bit ab, hit;
    do_reset();
    @(negedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_tx_send", 32'(bus.tx_send), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_abort", 32'(bus.abort), 0);

    tx_len_fix = 10;
    push_pkt(0, 8'h41, 8'h35, 2);
    run_phase(200);
    chk("t1_grant_idle", 32'(bus.grant), 0);
    push_pkt(0, 8'h51, 8'h00, 1);
    push_pkt(1, 8'h52, 8'h00, 1);
    run_phase(200);

    tx_len_fix = 0;
    do_reset();
    push_pkt(0, 8'h21, 8'h22, 2);
    push_pkt(1, 8'h31, 8'h32, 2);
    run_phase(300);

    for (int k = 0; k < 4; k++) begin
      push_pkt(0, 8'hA0, 8'h00, 1);
      push_pkt(1, 8'hB1, 8'h00, 1);
    end
    run_phase(400);

    do_reset();
    exp_q.push_back(exp_t'{req: 2'd1, data: 8'h11});
    bus.req_valid = 2'b10;
    bus.req_data = {8'h11, 8'h00};
    bus.req_last = 2'b00;
    wait_accept(1, "t4_first_accept");
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_data = {8'h00, 8'h22};
    bus.req_last = 2'b01;
    cnt = 0;
    n = 0;
    ab = 0;
    while (!ab && n < 80) begin
      @(negedge clk);
      #1;
      n++;
      if (bus.req_ready[1]) cnt++;
      ab = bus.abort;
    end
    chk("t4_abort", 32'(ab), 1);
    chk("t4_gap_cycles", cnt, GAP_T);
    chk("t4_abort_owner", 32'(bus.grant), 2);
    @(negedge clk);
    #1;
    chk("t4_idle_grant", 32'(bus.grant), 0);
    chk("t4_abort_pulse", 32'(bus.abort), 0);
    @(negedge clk);
    #1;
    chk("t4_next_grant", 32'(bus.grant), 1);
    bus.req_valid = '0;
    push_pkt(0, 8'h22, 8'h00, 1);
    m_ptr = 0;
    run_phase(200);

    tx_lost = 1;
    send_t.delete();
    q_d[0].push_back(8'hC1); q_l[0].push_back(1'b0);
    q_d[0].push_back(8'hC2); q_l[0].push_back(1'b0);
    q_d[0].push_back(8'hC3); q_l[0].push_back(1'b1);
    run_phase(200);
    chk("t5_sends", send_t.size(), 3);
    for (int k = 1; k < send_t.size(); k++)
      chk("t5_interval", send_t[k] - send_t[k-1], START_T + 2);
    chk("t5_busy", 32'(bus.busy), 0);
    tx_lost = 0;

    do_reset();
    tx_len_fix = 20;
    exp_q.push_back(exp_t'{req: 2'd0, data: 8'h61});
    bus.req_valid = 2'b01;
    bus.req_data = {8'h00, 8'h61};
    bus.req_last = 2'b00;
    wait_accept(0, "t6_accept");
    @(negedge clk);
    bus.req_valid = '0;
    n = 0;
    hit = 0;
    while (!hit && n < 30) begin
      @(negedge clk);
      #1;
      n++;
      hit = bus.busy & bus.tx_active & !bus.tx_send;
    end
    chk("t6_wait_done", 32'(hit), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_grant", 32'(bus.grant), 0);
    chk("t6_ready", 32'(bus.req_ready), 0);
    chk("t6_tx_send", 32'(bus.tx_send), 0);
    chk("t6_tx_data", 32'(bus.tx_data), 0);
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_abort", 32'(bus.abort), 0);
    tx_len_fix = 0;
    do_reset();
    push_pkt(0, 8'h71, 8'h00, 1);
    push_pkt(1, 8'h72, 8'h00, 1);
    run_phase(200);

    gap_en = 1;
    tx_rnd_lost = 1;
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NR; i++) begin
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            q_d[i].push_back(8'($urandom));
            q_l[i].push_back(b == len - 1);
          end
        end
      end
      run_phase(2000);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
